// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive side of a multiplexed 7-segment scan bus. The bus is registered,
//   each stable dwell of {an,c} is sampled once, the hex glyph is decoded, and
//   digits 0..NDIG-1 are reassembled into one value. Blanking, out-of-order
//   digits and non-hex glyphs are flagged.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active low
//   c[6:0]     scanned cathodes, active low (bit6 = g ... bit0 = a)
//   an[7:0]    scanned anode enables, active low
//   value      last completely decoded value, digit k in value[4k+3:4k]
//   valid      one-cycle pulse, value updated this cycle
//   blank      level, the bus is showing the blank/clear pattern
//   frame_err  one-cycle pulse, a digit arrived out of sequence
//   digit_err  one-cycle pulse, a sampled cathode pattern is not a hex glyph
module seg_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        c,
  input  logic [7:0]        an,
  output logic [4*NDIG-1:0] value,
  output logic              valid,
  output logic              blank,
  output logic              frame_err,
  output logic              digit_err
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [2:0] LAST_IDX  = 3'(NDIG - 1);

  logic [7:0]        r_an_q, r_an_d;
  logic [6:0]        r_c_q, r_c_d;
  logic [14:0]       prev_q, prev_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              smp_q, smp_d;
  logic [7:0]        smp_an_q, smp_an_d;
  logic [6:0]        smp_c_q, smp_c_d;
  state_t            state_q, state_d;
  logic [2:0]        e_q, e_d;
  logic [4*NDIG-1:0] asm_q, asm_d;
  logic [4*NDIG-1:0] value_q, value_d;
  logic              valid_q, valid_d;
  logic              blank_q, blank_d;
  logic              frame_err_q, frame_err_d;
  logic              digit_err_q, digit_err_d;

  logic              is_digit, is_blank, high_ok;
  logic [2:0]        dig_k;
  int                zeros;
  logic              glyph_ok;
  logic [3:0]        glyph_nib;

  // Inverse of the hex glyph table: returns {recognised, nibble}.
  function automatic logic [4:0] glyph_dec(input logic [6:0] p);
    case (p)
      7'b1000000: glyph_dec = 5'h10;
      7'b1111001: glyph_dec = 5'h11;
      7'b0100100: glyph_dec = 5'h12;
      7'b0110000: glyph_dec = 5'h13;
      7'b0011001: glyph_dec = 5'h14;
      7'b0010010: glyph_dec = 5'h15;
      7'b0000010: glyph_dec = 5'h16;
      7'b1111000: glyph_dec = 5'h17;
      7'b0000000: glyph_dec = 5'h18;
      7'b0010000: glyph_dec = 5'h19;
      7'b0001000: glyph_dec = 5'h1A;
      7'b0000011: glyph_dec = 5'h1B;
      7'b1000110: glyph_dec = 5'h1C;
      7'b0100001: glyph_dec = 5'h1D;
      7'b0000110: glyph_dec = 5'h1E;
      7'b0001110: glyph_dec = 5'h1F;
      default:    glyph_dec = 5'h00;
    endcase
  endfunction

  // Stage 0 -> 1: input register and stability counter. The strobe fires
  // once per dwell; saturation keeps a long dwell from re-firing.
  always_comb begin
    r_an_d = an;
    r_c_d  = c;
    prev_d = {r_an_q, r_c_q};
    if ({r_an_q, r_c_q} != prev_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q >= SETTLE_C) begin
      cnt_d = SETTLE_C;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    smp_d    = (cnt_d == SETTLE_M1);
    smp_an_d = r_an_q;
    smp_c_d  = r_c_q;
  end

  // Stage 1 -> 2: classify the sampled pattern.
  always_comb begin
    zeros   = 0;
    dig_k   = 3'd0;
    high_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < NDIG) begin
        if (!smp_an_q[i]) begin
          zeros = zeros + 1;
          dig_k = 3'(i);
        end
      end else if (!smp_an_q[i]) begin
        high_ok = 1'b0;
      end
    end
    is_digit = high_ok && (zeros == 1);
    is_blank = (smp_an_q == 8'h00) && (smp_c_q == 7'b1000000);
  end

  assign {glyph_ok, glyph_nib} = glyph_dec(smp_c_q);

  // FSM next state.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    if (smp_q) begin
      if (is_blank) begin
        state_d = IDLE;
      end else if (is_digit) begin
        if (!glyph_ok) begin
          state_d = IDLE;
        end else if (state_q == IDLE) begin
          if (dig_k == 3'd0) begin
            state_d = COLLECT;
            e_d     = 3'd1;
          end
        end else if (dig_k == e_q) begin
          if (e_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            e_d = e_q + 3'd1;
          end
        end else if (dig_k == 3'd0) begin
          // Out-of-order digit 0 restarts the frame rather than dropping it.
          e_d = 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // FSM outputs and assembly datapath.
  always_comb begin
    asm_d       = asm_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    blank_d     = blank_q;
    frame_err_d = 1'b0;
    digit_err_d = 1'b0;
    if (smp_q) begin
      if (is_blank) begin
        value_d = '0;
        blank_d = 1'b1;
      end else if (is_digit) begin
        if (!glyph_ok) begin
          digit_err_d = 1'b1;
        end else if (state_q == IDLE) begin
          if (dig_k == 3'd0) begin
            asm_d[3:0] = glyph_nib;
          end
        end else if (dig_k == e_q) begin
          for (int k = 0; k < NDIG; k++) begin
            if (3'(k) == dig_k) asm_d[4*k +: 4] = glyph_nib;
          end
          if (e_q == LAST_IDX) begin
            value_d = asm_d;
            valid_d = 1'b1;
            blank_d = 1'b0;
          end
        end else begin
          frame_err_d = 1'b1;
          if (dig_k == 3'd0) asm_d[3:0] = glyph_nib;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      e_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_an_q      <= 8'hFF;
      r_c_q       <= 7'h7F;
      prev_q      <= {8'hFF, 7'h7F};
      cnt_q       <= 4'd0;
      smp_q       <= 1'b0;
      asm_q       <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      blank_q     <= 1'b0;
      frame_err_q <= 1'b0;
      digit_err_q <= 1'b0;
    end else begin
      r_an_q      <= r_an_d;
      r_c_q       <= r_c_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      smp_q       <= smp_d;
      asm_q       <= asm_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      frame_err_q <= frame_err_d;
      digit_err_q <= digit_err_d;
    end
  end

  // Sampled pattern: qualified by smp_q, so it needs no reset.
  always_ff @(posedge clk) begin
    smp_an_q <= smp_an_d;
    smp_c_q  <= smp_c_d;
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign blank     = blank_q;
  assign frame_err = frame_err_q;
  assign digit_err = digit_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Bench for seg_scan_decoder: directed scan scenarios plus randomized bus
//   traffic, checked every cycle against a behavioural model of the decoder.
module tb_seg_scan_decoder;

  localparam int NDIG   = 4;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  c;
  logic [7:0]  an;
  logic [15:0] value;
  logic        valid, blank, frame_err, digit_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .c(c), .an(an),
    .value(value), .valid(valid), .blank(blank),
    .frame_err(frame_err), .digit_err(digit_err)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic [14:0] m_r;          // pin pattern as seen one cycle late
  int          m_n;          // cycles m_r has held its value
  bit          m_s_v;        // a dwell was sampled, outputs follow next edge
  logic [14:0] m_s;
  bit          m_in_frame;
  int          m_e;
  logic [3:0]  m_nib [NDIG];
  logic [15:0] x_value;
  bit          x_valid, x_blank, x_ferr, x_derr;

  task automatic model_sample(input logic [14:0] s);
    logic [7:0] a;
    logic [6:0] p;
    int zeros, k, g;
    bit hi_ok;
    a = s[14:7];
    p = s[6:0];
    zeros = 0; k = 0; hi_ok = 1; g = -1;
    for (int i = 0; i < 8; i++) begin
      if (i < NDIG) begin
        if (!a[i]) begin zeros++; k = i; end
      end else if (!a[i]) hi_ok = 0;
    end
    for (int i = 0; i < 16; i++) if (hex_glyph(4'(i)) == p) g = i;
    if (a == 8'h00 && p == 7'b1000000) begin
      x_value = 16'h0; x_blank = 1; m_in_frame = 0;
    end else if (hi_ok && zeros == 1) begin
      if (g < 0) begin
        x_derr = 1; m_in_frame = 0;
      end else if (!m_in_frame) begin
        if (k == 0) begin m_nib[0] = 4'(g); m_in_frame = 1; m_e = 1; end
      end else if (k == m_e) begin
        m_nib[k] = 4'(g);
        if (m_e == NDIG - 1) begin
          for (int j = 0; j < NDIG; j++) x_value[4*j +: 4] = m_nib[j];
          x_valid = 1; x_blank = 0; m_in_frame = 0;
        end else m_e++;
      end else begin
        x_ferr = 1;
        if (k == 0) begin m_nib[0] = 4'(g); m_e = 1; end
        else m_in_frame = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_r = {8'hFF, 7'h7F}; m_n = 1; m_s_v = 0; m_s = '0;
      m_in_frame = 0; m_e = 0;
      x_value = 16'h0; x_valid = 0; x_blank = 0; x_ferr = 0; x_derr = 0;
    end else begin
      x_valid = 0; x_ferr = 0; x_derr = 0;
      if (m_s_v) model_sample(m_s);
      m_s_v = (m_n == SETTLE);
      m_s   = m_r;
      if ({an, c} == m_r) m_n = (m_n < 1000) ? m_n + 1 : m_n;
      else m_n = 1;
      m_r = {an, c};
    end
  end

  // ---------------- compare process ----------------
  int n_valid = 0, n_ferr = 0, n_derr = 0;

  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      chk("outputs{value,valid,blank,ferr,derr}",
          32'({value, valid, blank, frame_err, digit_err}),
          32'({x_value, x_valid, x_blank, x_ferr, x_derr}));
      chk("pulse_exclusive", 32'($countones({valid, frame_err, digit_err}) <= 1), 32'd1);
      if (valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_ferr++;
      if (digit_err === 1'b1) n_derr++;
    end
  end

  // ---------------- stimulus ----------------
  int s_v, s_f, s_d;

  task automatic mark();
    s_v = n_valid; s_f = n_ferr; s_d = n_derr;
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] p, input int len);
    repeat (len) begin
      @(negedge clk);
      an = a;
      c  = p;
    end
  endtask

  task automatic digit(input int k, input logic [3:0] n, input int len);
    logic [7:0] a;
    a = 8'hFF;
    a[k] = 1'b0;
    drive(a, hex_glyph(n), len);
  endtask

  task automatic scan(input logic [15:0] v);
    for (int k = 0; k < 4; k++) digit(k, v[4*k +: 4], 4);
  endtask

  task automatic idle(input int len);
    drive(8'hFF, 7'h7F, len);
  endtask

  task automatic counts(input string tag, input int ev, input int ef, input int ed);
    chk({tag, "_valid_pulses"}, 32'(n_valid - s_v), 32'(ev));
    chk({tag, "_frame_err_pulses"}, 32'(n_ferr - s_f), 32'(ef));
    chk({tag, "_digit_err_pulses"}, 32'(n_derr - s_d), 32'(ed));
  endtask

  initial begin : stim
    int seq, kind, len;
    logic [7:0] ra;
    rst = 1'b0; an = 8'hFF; c = 7'h7F;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({value, valid, blank, frame_err, digit_err}), 32'h0);
    rst = 1'b1;
    idle(4);

    // plain frame
    mark(); scan(16'h1234); idle(6);
    chk("s1_value", 32'(value), 32'h1234);
    chk("s1_model_value", 32'(x_value), 32'h1234);
    chk("s1_blank", 32'(blank), 32'h0);
    counts("s1", 1, 0, 0);

    // rescan, blank, new frame
    mark(); scan(16'h1234); idle(2);
    counts("s2_rescan", 1, 0, 0);
    mark(); drive(8'h00, 7'b1000000, 3); idle(6);
    chk("s2_blank", 32'(blank), 32'h1);
    chk("s2_blank_value", 32'(value), 32'h0);
    counts("s2_blank", 0, 0, 0);
    mark(); scan(16'hABCD); idle(6);
    chk("s2_value", 32'(value), 32'hABCD);
    chk("s2_model_value", 32'(x_value), 32'hABCD);
    chk("s2_blank_cleared", 32'(blank), 32'h0);
    counts("s2_abcd", 1, 0, 0);

    // skipped digit
    mark(); digit(0, 4'h4, 4); digit(2, 4'h2, 4); idle(6);
    chk("s3_value_held", 32'(value), 32'hABCD);
    counts("s3_skip", 0, 1, 0);
    mark(); scan(16'h5678); idle(6);
    chk("s3_value", 32'(value), 32'h5678);
    counts("s3_5678", 1, 0, 0);

    // bad glyph, then a glitch between dwells
    mark(); digit(0, 4'h4, 4); drive(8'hFD, 7'h7F, 4); idle(6);
    chk("s4_value_held", 32'(value), 32'h5678);
    counts("s4_badglyph", 0, 0, 1);
    mark();
    digit(0, 4'h4, 4); drive(8'hFD, 7'h00, 1);
    digit(1, 4'h3, 4); digit(2, 4'h2, 4); digit(3, 4'h1, 4); idle(6);
    chk("s4_value", 32'(value), 32'h1234);
    counts("s4_glitch", 1, 0, 0);

    // mid-frame entry
    mark();
    digit(2, 4'h9, 4); digit(3, 4'hE, 4);
    scan(16'h4321); idle(6);
    chk("s5_value", 32'(value), 32'h4321);
    counts("s5_midentry", 1, 0, 0);

    // reset mid-frame
    mark();
    digit(0, 4'h5, 4); digit(1, 4'h6, 4); digit(2, 4'h7, 4);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("s6_reset_outputs", 32'({value, valid, blank, frame_err, digit_err}), 32'h0);
    rst = 1'b1;
    digit(3, 4'h8, 4); idle(6);
    chk("s6_value", 32'(value), 32'h0);
    counts("s6_reset", 0, 0, 0);

    // randomized traffic
    seq = 0;
    for (int it = 0; it < 500; it++) begin
      kind = $urandom_range(0, 19);
      len  = $urandom_range(1, 5);
      if (kind <= 11) begin
        digit(seq, 4'($urandom_range(0, 15)), len);
        seq = (seq + 1) % NDIG;
      end else if (kind <= 13) begin
        digit($urandom_range(0, NDIG - 1), 4'($urandom_range(0, 15)), len);
      end else if (kind == 14) begin
        drive(8'h00, 7'b1000000, len);
      end else if (kind <= 16) begin
        ra = 8'hFF;
        ra[$urandom_range(0, NDIG - 1)] = 1'b0;
        drive(ra, 7'($urandom_range(0, 127)), len);
      end else if (kind == 17) begin
        drive(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), len);
      end else if (kind == 18) begin
        idle(len);
      end else begin
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        seq = 0;
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment scan bus (active-low cathodes c[6:0], active-low anodes an[7:0]).
- Samples the scanned bus, inverts the hex segment encoding and reassembles the 16-bit value shown on digits 0..3.
- Flags blanking, malformed frames and undecodable patterns.
- Used as an on-board loopback checker for the display path and as a bench monitor.

Parameters:
- NDIG, 4, number of scanned digits; value width is 4*NDIG.
- SETTLE, 2, consecutive cycles an identical {an,c} must be present before it is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- c  in  7  scanned cathode pattern, active-low; bit6 = g ... bit0 = a.
- an  in  8  scanned anode enables, active-low.
- value  out  16  last completely decoded value; digit k is value[4k+3:4k].
- valid  out  1  one-cycle pulse; value was updated this cycle.
- blank  out  1  level; the bus is in the blank/clear pattern.
- frame_err  out  1  one-cycle pulse; a digit arrived out of sequence.
- digit_err  out  1  one-cycle pulse; a sampled cathode pattern is not a hex glyph.

Behaviour:
- Reset: rst==0 sampled at posedge clk forces the following state.
  - value=0, valid=0, blank=0, frame_err=0, digit_err=0.
  - Input registers r_an=8'hFF, r_c=7'h7F.
  - Stability counter=0, FSM=IDLE, assembly register=0.
  - Reset asserted mid-frame discards the partial frame with no pulses.
- Input stage: an and c are registered every cycle. All decoding uses r_an and r_c.
- Stability:
  - The counter clears when {r_an,r_c} differs from the previous cycle's value, otherwise increments, saturating at SETTLE.
  - sample_stb fires exactly once per dwell, on the cycle the counter reaches SETTLE-1 with the value unchanged (SETTLE=1: first cycle of the new value).
  - Shorter dwells are ignored with no error.
- Anode classification, at sample_stb:
  - DIGIT k: r_an[NDIG-1:0] has exactly one zero, at bit k, and r_an[7:NDIG] all ones.
  - BLANK: r_an==8'h00 and r_c==7'b1000000.
  - NONE: anything else; ignored and the FSM state is unchanged.
- Glyph decode is the exact inverse of the hex table:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Any other pattern on a DIGIT sample: digit_err pulses the next cycle, the FSM goes to IDLE, and the frame is discarded.
- FSM states are IDLE and COLLECT(expected index e).
  - IDLE + DIGIT 0 → store nibble, go to COLLECT(e=1).
  - IDLE + DIGIT k≠0 → stay in IDLE, no error (mid-frame entry).
  - COLLECT(e) + DIGIT e → store nibble. If e==NDIG-1, the next cycle loads value from the assembly register plus the new nibble, pulses valid, clears blank and returns to IDLE; otherwise e←e+1.
  - COLLECT(e) + DIGIT k≠e → frame_err pulses the next cycle. If k==0, restart COLLECT(e=1) with the new nibble; otherwise go to IDLE.
  - Any state + BLANK → next cycle value=0 and blank=1, no valid pulse, FSM goes to IDLE. A frame in progress is aborted silently.
- Latency: valid rises 1+SETTLE cycles after the last digit's pattern first appears on the pins, plus one output-register cycle.
- A repeated long dwell of the same digit produces one sample only; a rescan of the same value produces valid again with an unchanged value.
- At most one of valid, frame_err, digit_err is asserted in any cycle.

Test Plan:
- SETTLE=2, each dwell 4 cycles, scan (an=FE,c=0011001),(FD,0110000),(FB,0100100),(F7,1111001) → single valid pulse, value=16'h1234, blank=0, no error pulses.
- Scan the 0x1234 frame, then an=00, c=1000000 for 3 cycles → blank=1, value=16'h0000, no valid; a following scan of 0xABCD → valid, value=16'hABCD, blank=0.
- Digit0 '4' then an=FB '2' (digit 1 skipped) → frame_err one pulse, no valid, value holds its prior value; the next full 0x5678 scan → valid, value=16'h5678.
- Digit1 with c=1111111 → digit_err one pulse, frame discarded; a single-cycle glitch an=FD c=0000000 between dwells → ignored, frame 0x1234 still decodes.
- Scan starting at digit 2 (2,3,0,1,2,3) → exactly one valid, for the frame begun at digit 0.
- rst=0 for 1 cycle after digits 0..2 of a frame → all outputs 0, and completing digit 3 alone → no valid.
